// File: rtl/fb_swap_ctrl.sv
// Ping-pong framebuffer swap controller: exchanges the scanout and writer banks
// at scanout frame boundaries once the writer has a full frame ready.
module fb_swap_ctrl #(
  parameter int MIN_SHOWS    = 1,
  parameter int STALE_FRAMES = 120
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        full,
  input  logic        frame_done,
  input  logic        enable,
  output logic        swapped,
  output logic        rd_bank,
  output logic        wr_bank,
  output logic [7:0]  show_cnt,
  output logic [15:0] frame_cnt,
  output logic        stale
);

  localparam logic [1:0] S_WAIT   = 2'd0;
  localparam logic [1:0] S_SWAP   = 2'd1;
  localparam logic [1:0] S_SETTLE = 2'd2;

  localparam logic [8:0] MIN_SHOWS_V    = 9'(MIN_SHOWS);
  localparam logic [7:0] STALE_FRAMES_V = 8'(STALE_FRAMES);

  logic [1:0]  r_state;
  logic        r_swapped;
  logic        r_rd_bank;
  logic [7:0]  r_show_cnt;
  logic [15:0] r_frame_cnt;
  logic        r_stale;

  logic        w_go;
  logic [7:0]  w_show_inc;

  // The frame_done arriving now counts as one more show, hence the +1.
  assign w_go = (r_state == S_WAIT) & full & frame_done & enable &
                (({1'b0, r_show_cnt} + 9'd1) >= MIN_SHOWS_V);

  assign w_show_inc = (r_show_cnt == 8'hFF) ? r_show_cnt : r_show_cnt + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_WAIT;
      r_swapped   <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_show_cnt  <= 8'd0;
      r_frame_cnt <= 16'd0;
      r_stale     <= 1'b0;
    end else begin
      r_swapped <= w_go;

      case (r_state)
        S_WAIT:   if (w_go) r_state <= S_SWAP;
        S_SWAP:   r_state <= S_SETTLE;
        // Hold off until the writer drops full, so one frame never swaps twice.
        S_SETTLE: if (!full) r_state <= S_WAIT;
        default:  r_state <= S_WAIT;
      endcase

      if (w_go) begin
        r_rd_bank   <= ~r_rd_bank;
        r_show_cnt  <= 8'd0;
        r_frame_cnt <= r_frame_cnt + 16'd1;
        r_stale     <= 1'b0;
      end else if (frame_done) begin
        r_show_cnt <= w_show_inc;
        if (w_show_inc == STALE_FRAMES_V) r_stale <= 1'b1;
      end
    end
  end

  assign swapped   = r_swapped;
  assign rd_bank   = r_rd_bank;
  assign wr_bank   = ~r_rd_bank;
  assign show_cnt  = r_show_cnt;
  assign frame_cnt = r_frame_cnt;
  assign stale     = r_stale;

endmodule
